// File: rtl/memarb_pkg.sv
// Shared definitions for the mem_arbiter_n memory arbiter: mode constants,
// round-robin state encoding and a constant-foldable ceil(log2) helper.
package memarb_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  typedef enum logic {
    RR_IDLE  = 1'b0,
    RR_GRANT = 1'b1
  } rr_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_n_rr_pick.sv
// Round-robin winner search: first requester at or above ptr, wrapping.
// Purely combinational; found is low when no channel requests.
module rr_pick
  import memarb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]        req,
  input  logic [clog2(NUM_CH)-1:0] ptr,
  output logic [clog2(NUM_CH)-1:0] win,
  output logic                     found
);

  localparam int CW = clog2(NUM_CH);

  logic [CW-1:0] idx;

  // Scan from the far end down so the candidate closest to ptr wins last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CW'((int'(ptr) + i) % NUM_CH);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter: round-robin on requests or fixed TDM slot owners.
// Define MEMARB_HOLD_LIMIT_EN to cap RR grants at MAX_HOLD cycles when others wait.
module mem_arbiter_n
  import memarb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SLOT_CNT = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [NUM_CH-1:0]          req,
  output logic [NUM_CH-1:0]          gnt,
  output logic                       gnt_valid,
  output logic [clog2(NUM_CH)-1:0]   gnt_id,
  output logic [clog2(SLOT_CNT)-1:0] slot,
  output logic                       preempt
);

  localparam int CW = clog2(NUM_CH);
  localparam int SW = clog2(SLOT_CNT);

  if (NUM_CH < 2 || NUM_CH > 8 || SLOT_CNT < NUM_CH || SLOT_CNT > 256 ||
      MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("mem_arbiter_n: illegal parameter set");
  end

  logic          mode_q;
  rr_state_t     state_q;
  logic [CW-1:0] ptr_q;
  logic [CW-1:0] tdm_own_q;
  logic          slot_last;
  logic [CW-1:0] pick_win;
  logic          pick_found;
  logic          issue;
  logic          go_idle;
  logic [CW-1:0] issue_id;

`ifdef MEMARB_HOLD_LIMIT_EN
  localparam int HW = clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q;
  logic          force_rel;
`endif

  function automatic logic [CW-1:0] inc_ch(input logic [CW-1:0] i);
    return (i == CW'(NUM_CH - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .win   (pick_win),
    .found (pick_found)
  );

  assign slot_last = (slot == SW'(SLOT_CNT - 1));

  // Next-grant decision. While granted, ptr_q already equals owner+1, so the
  // picker naturally hands over to the next channel after the owner.
  always_comb begin
    issue    = 1'b0;
    go_idle  = 1'b0;
    issue_id = pick_win;
`ifdef MEMARB_HOLD_LIMIT_EN
    force_rel = 1'b0;
`endif
    if (mode_q == MODE_TDM) begin
      issue_id = tdm_own_q;
      issue    = req[tdm_own_q];
      go_idle  = ~req[tdm_own_q];
    end else if (state_q == RR_IDLE) begin
      issue = pick_found;
    end else if (!req[gnt_id]) begin
      issue   = pick_found;
      go_idle = ~pick_found;
    end
`ifdef MEMARB_HOLD_LIMIT_EN
    else if (hold_q == HW'(MAX_HOLD) && |(req & ~gnt)) begin
      issue     = 1'b1;
      force_rel = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_RR;
      state_q   <= RR_IDLE;
      ptr_q     <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      slot      <= '0;
      tdm_own_q <= '0;
`ifdef MEMARB_HOLD_LIMIT_EN
      hold_q    <= '0;
      preempt   <= 1'b0;
`endif
    end else begin
      mode_q <= mode;
      if (slot_last) begin
        slot      <= '0;
        tdm_own_q <= '0;
      end else begin
        slot      <= slot + 1'b1;
        tdm_own_q <= inc_ch(tdm_own_q);
      end
`ifdef MEMARB_HOLD_LIMIT_EN
      preempt <= 1'b0;
`endif
      // A mode change costs one dead grant cycle and restarts the slot schedule.
      if (mode != mode_q) begin
        state_q   <= RR_IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
        slot      <= '0;
        tdm_own_q <= '0;
      end else if (issue) begin
        gnt       <= onehot(issue_id);
        gnt_valid <= 1'b1;
        gnt_id    <= issue_id;
        if (mode_q == MODE_RR) begin
          state_q <= RR_GRANT;
          ptr_q   <= inc_ch(issue_id);
`ifdef MEMARB_HOLD_LIMIT_EN
          hold_q  <= HW'(1);
          preempt <= force_rel;
`endif
        end
      end else if (go_idle) begin
        state_q   <= RR_IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
      end
`ifdef MEMARB_HOLD_LIMIT_EN
      else if (state_q == RR_GRANT && hold_q != HW'(MAX_HOLD)) begin
        hold_q <= hold_q + 1'b1;
      end
`endif
    end
  end

`ifndef MEMARB_HOLD_LIMIT_EN
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: directed scenarios then random traffic, all checked
// against a cycle-level behavioural model of the arbitration rules.
module tb_mem_arbiter_n;

  localparam int NUM_CH   = 4;
  localparam int SLOT_CNT = 8;
  localparam int MAX_HOLD = 16;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [2:0] slot;
  logic       preempt;

  int errors = 0;
  int checks = 0;

  int m_mode, m_owner, m_ptr, m_slot, m_hold, m_pre;

  mem_arbiter_n #(.NUM_CH(NUM_CH), .SLOT_CNT(SLOT_CNT), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .slot      (slot),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit has(input logic [3:0] r, input int i);
    logic [3:0] t;
    t = r >> i;
    return t[0];
  endfunction

  function automatic int rr_winner(input logic [3:0] r, input int from);
    for (int k = 0; k < NUM_CH; k++)
      if (has(r, (from + k) % NUM_CH)) return (from + k) % NUM_CH;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = -1; m_ptr = 0; m_slot = 0; m_hold = 0; m_pre = 0;
  endtask

  // One clock edge of the arbitration rules, using the inputs seen at that edge.
  task automatic model_edge();
    int w;
    logic [3:0] r;
    r = req;
    m_pre = 0;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_owner = -1; m_slot = 0; m_hold = 0;
      return;
    end
    if (m_mode == 1) begin
      w = m_slot % NUM_CH;
      m_owner = has(r, w) ? w : -1;
      m_slot = (m_slot + 1) % SLOT_CNT;
      return;
    end
    m_slot = (m_slot + 1) % SLOT_CNT;
    w = -1;
    if (m_owner < 0) begin
      w = rr_winner(r, m_ptr);
    end else if (!has(r, m_owner)) begin
      w = rr_winner(r, (m_owner + 1) % NUM_CH);
      if (w < 0) m_owner = -1;
    end else begin
`ifdef MEMARB_HOLD_LIMIT_EN
      if (m_hold == MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        w = rr_winner(r, (m_owner + 1) % NUM_CH);
        m_pre = 1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
`endif
    end
    if (w >= 0) begin
      m_owner = w; m_ptr = (w + 1) % NUM_CH; m_hold = 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt",       32'(gnt),       32'(m_owner < 0 ? 0 : (1 << m_owner)));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("gnt_id",    32'(gnt_id),    32'(m_owner < 0 ? 0 : m_owner));
    chk("slot",      32'(slot),      32'(m_slot));
    chk("preempt",   32'(preempt),   32'(m_pre));
    chk("onehot",    32'($onehot0(gnt)), 32'd1);
  endtask

  initial begin
    int idle_cnt, ch0_cnt, pre_cnt, ch0_exp, pre_exp;
    logic [3:0] first_other, other_exp;

    rst = 1'b0; mode = 1'b0; req = 4'b0000;
    model_reset();
    @(posedge clk); #1;
    chk("rst_gnt",       32'(gnt),       32'd0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt_id",    32'(gnt_id),    32'd0);
    chk("rst_slot",      32'(slot),      32'd0);
    chk("rst_preempt",   32'(preempt),   32'd0);
    @(posedge clk); #1;
    rst = 1'b1; mode = 1'b1; req = 4'b1111;

    // TDM schedule after the mode switch
    cyc();
    chk("tdm_switch_gnt", 32'(gnt), 32'd0);
    chk("tdm_switch_slot", 32'(slot), 32'd0);
    cyc();
    chk("tdm_first", 32'(gnt), 32'b0001);
    for (int k = 1; k < 4; k++) begin
      cyc();
      chk("tdm_seq", 32'(gnt), 32'(1 << k));
    end
    for (int k = 0; k < 5; k++) cyc();
    req = 4'b1011;
    idle_cnt = 0;
    for (int k = 0; k < SLOT_CNT; k++) begin
      cyc();
      if (gnt == 4'b0000) idle_cnt++;
    end
    chk("tdm_idle_slots", 32'(idle_cnt), 32'd2);

    // Round robin, each owner drops req for one cycle after three granted cycles
    mode = 1'b0; req = 4'b1111;
    cyc();
    chk("rr_switch_gnt", 32'(gnt), 32'd0);
    cyc();
    for (int n = 0; n < 5; n++) begin
      chk("rr_order", 32'(gnt_id), 32'(n % NUM_CH));
      cyc();
      cyc();
      req = req & ~(4'b0001 << (n % NUM_CH));
      cyc();
      req = 4'b1111;
    end

    // Pointer wrap
    req = 4'b0000; cyc();
    req = 4'b0010; cyc();
    chk("ptr_setup", 32'(gnt), 32'b0010);
    req = 4'b0000; cyc();
    req = 4'b0011; cyc();
    chk("ptr_wrap", 32'(gnt), 32'b0001);
    req = 4'b0000; cyc();
    req = 4'b0011; cyc();
    chk("ptr_next", 32'(gnt), 32'b0010);

    // Hold limit
    req = 4'b0000; cyc();
    req = 4'b0001; cyc();
    ch0_cnt = (gnt == 4'b0001) ? 1 : 0;
    pre_cnt = 0;
    first_other = 4'b0000;
    for (int i = 1; i < 25; i++) begin
      if (i == 4) req = 4'b1001;
      cyc();
      if (gnt == 4'b0001) ch0_cnt++;
      if (preempt) pre_cnt++;
      if (gnt != 4'b0001 && first_other == 4'b0000) first_other = gnt;
    end
`ifdef MEMARB_HOLD_LIMIT_EN
    ch0_exp = MAX_HOLD; pre_exp = 1; other_exp = 4'b1000;
`else
    ch0_exp = 25; pre_exp = 0; other_exp = 4'b0000;
`endif
    chk("hold_ch0_cycles", 32'(ch0_cnt), 32'(ch0_exp));
    chk("hold_preempts", 32'(pre_cnt), 32'(pre_exp));
    chk("hold_next_gnt", 32'(first_other), 32'(other_exp));

    // Mode switch during a ch1 grant
    req = 4'b0000; cyc();
    req = 4'b0010; cyc();
    chk("msw_ch1", 32'(gnt), 32'b0010);
    mode = 1'b1; req = 4'b1111;
    cyc();
    chk("msw_dead_gnt", 32'(gnt), 32'd0);
    chk("msw_slot0", 32'(slot), 32'd0);
    cyc();
    chk("msw_tdm_first", 32'(gnt), 32'b0001);

    // Reset in the middle of a grant
    mode = 1'b0; req = 4'b0100;
    cyc();
    cyc();
    chk("mrst_pre_valid", 32'(gnt_valid), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mrst_gnt",       32'(gnt),       32'd0);
    chk("mrst_gnt_valid", 32'(gnt_valid), 32'd0);
    chk("mrst_gnt_id",    32'(gnt_id),    32'd0);
    chk("mrst_slot",      32'(slot),      32'd0);
    @(posedge clk); #1;
    rst = 1'b1; req = 4'b1000;
    cyc();
    chk("mrst_first", 32'(gnt), 32'b1000);

    // Random traffic with occasional mode flips
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 5) == 0) req = req ^ (4'b0001 << c);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
